// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the datapath: instruction/flag in, strobes out.
interface control_sequencer_if;
   logic [15:0] IROUT;
   logic        ZFLAG;
   logic [11:0] WEN;
   logic [11:0] REN;
   logic [5:0]  LDALU;
   logic [6:0]  RSTR;
   logic        R2INC;
   logic        PCINC;
   logic        MEMREAD;
   logic        MEMWRITE;
   logic [2:0]  ALUMUX;

   modport master (
      input  IROUT, ZFLAG,
      output WEN, REN, LDALU, RSTR, R2INC, PCINC, MEMREAD, MEMWRITE, ALUMUX
   );

   modport slave (
      output IROUT, ZFLAG,
      input  WEN, REN, LDALU, RSTR, R2INC, PCINC, MEMREAD, MEMWRITE, ALUMUX
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch / increment PC / decode / up to two execute cycles.
// Optional feature macro CTRL_SINGLE_STEP_EN adds a step input and parks in IDLE after each retire.
module control_sequencer (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic                       step,
`endif
   control_sequencer_if.master        bus,
   output logic                       halted,
   output logic                       err,
   output logic [15:0]                instr_count
);

   localparam int unsigned IdxAr = 0;
   localparam int unsigned IdxDr = 1;
   localparam int unsigned IdxPc = 2;
   localparam int unsigned IdxIr = 3;
   localparam int unsigned IdxAc = 11;

   localparam int unsigned LdIr = 0;
   localparam int unsigned LdAc = 5;

   localparam logic [3:0] OpNop   = 4'h0;
   localparam logic [3:0] OpLdac  = 4'h1;
   localparam logic [3:0] OpStac  = 4'h2;
   localparam logic [3:0] OpMvar  = 4'h3;
   localparam logic [3:0] OpAlu   = 4'h4;
   localparam logic [3:0] OpIncr2 = 4'h5;
   localparam logic [3:0] OpClr   = 4'h6;
   localparam logic [3:0] OpJmp   = 4'h7;
   localparam logic [3:0] OpJmpz  = 4'h8;
   localparam logic [3:0] OpHalt  = 4'hF;

   typedef enum logic [2:0] {
      StIdle, StFetch, StIncPc, StDecode, StEx1, StEx2, StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        zflag_q, zflag_d;
   logic        err_q, err_d;
   logic [15:0] count_q, count_d;

   logic [3:0]  op;
   logic [2:0]  fld;
   logic        go;
   logic        retire;
   state_e      retire_st;
   logic        unused_ir;

   assign op        = ir_q[15:12];
   assign fld       = ir_q[2:0];
   assign unused_ir = ^ir_q[8:3];

`ifdef CTRL_SINGLE_STEP_EN
   assign go        = start | step;
   assign retire_st = StIdle;
`else
   assign go        = start;
   assign retire_st = StFetch;
`endif

   // Register field 0 addresses AC; fields 1..7 address R1..R7 (WEN/REN bits 4..10).
   function automatic logic [11:0] reg_onehot(input logic [2:0] f);
      logic [11:0] oh;
      oh = '0;
      if (f == 3'd0) oh[IdxAc] = 1'b1;
      else           oh[4'(f) + 4'd3] = 1'b1;
      return oh;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ir_q    <= '0;
         zflag_q <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         zflag_q <= zflag_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      zflag_d = zflag_q;
      err_d   = err_q;
      count_d = count_q;
      retire  = 1'b0;
      case (state_q)
         StIdle:   if (go) state_d = StFetch;
         StFetch:  state_d = StIncPc;
         StIncPc:  state_d = StDecode;
         StDecode: begin
            ir_d    = bus.IROUT;
            // Zero flag is captured on the edge into EX1 so the EX1 outputs stay Moore.
            zflag_d = bus.ZFLAG;
            case (bus.IROUT[15:12])
               OpNop:   retire  = 1'b1;
               OpHalt:  state_d = StHalt;
               OpLdac, OpStac, OpMvar, OpAlu, OpIncr2, OpClr, OpJmp, OpJmpz:
                        state_d = StEx1;
               default: begin
                  state_d = StHalt;
                  err_d   = 1'b1;
               end
            endcase
         end
         StEx1: begin
            if (op == OpLdac || op == OpStac || op == OpAlu) state_d = StEx2;
            else                                              retire  = 1'b1;
         end
         StEx2:   retire  = 1'b1;
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
      if (retire) begin
         state_d = retire_st;
         count_d = count_q + 16'd1;
      end
   end

   logic [11:0] wen, ren;
   logic [5:0]  ldalu;
   logic [6:0]  rstr;
   logic        r2inc, pcinc, memread, memwrite;
   logic [2:0]  alumux;

   always_comb begin
      wen      = '0;
      ren      = '0;
      ldalu    = '0;
      rstr     = '0;
      r2inc    = 1'b0;
      pcinc    = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      alumux   = '0;
      case (state_q)
         StFetch:  wen[IdxIr]  = 1'b1;
         StIncPc:  pcinc       = 1'b1;
         StDecode: ldalu[LdIr] = 1'b1;
         StEx1: begin
            case (op)
               OpLdac: begin
                  memread    = 1'b1;
                  wen[IdxDr] = 1'b1;
               end
               OpStac: begin
                  ren[IdxAc] = 1'b1;
                  wen[IdxDr] = 1'b1;
               end
               OpMvar: begin
                  ren        = reg_onehot(fld);
                  wen[IdxAr] = 1'b1;
               end
               OpAlu: begin
                  ren         = reg_onehot(fld);
                  ldalu[LdAc] = 1'b1;
                  alumux      = ir_q[11:9];
               end
               OpIncr2: r2inc = 1'b1;
               OpClr:   if (fld != 3'd0) rstr[fld - 3'd1] = 1'b1;
               OpJmp: begin
                  ren[IdxIr] = 1'b1;
                  wen[IdxPc] = 1'b1;
               end
               OpJmpz: begin
                  if (zflag_q) begin
                     ren[IdxIr] = 1'b1;
                     wen[IdxPc] = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         StEx2: begin
            case (op)
               OpLdac: begin
                  ren[IdxDr] = 1'b1;
                  wen[IdxAc] = 1'b1;
               end
               OpStac:  memwrite   = 1'b1;
               OpAlu:   wen[IdxAc] = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign bus.WEN      = wen;
   assign bus.REN      = ren;
   assign bus.LDALU    = ldalu;
   assign bus.RSTR     = rstr;
   assign bus.R2INC    = r2inc;
   assign bus.PCINC    = pcinc;
   assign bus.MEMREAD  = memread;
   assign bus.MEMWRITE = memwrite;
   assign bus.ALUMUX   = alumux;

   assign halted      = (state_q == StHalt);
   assign err         = err_q;
   assign instr_count = count_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle pulse that begins execution from IDLE.
REQ-004 SHALL have port IROUT, input, 16: instruction from register file; opcode IROUT[15:12], ALU op IROUT[11:9], register field IROUT[2:0].
REQ-005 SHALL have port ZFLAG, input, 1: ALU zero flag.
REQ-006 SHALL have port WEN, output, 12: write enables; bit order [0]AR [1]DR [2]PC [3]IR [4..10]R1..R7 [11]AC.
REQ-007 SHALL have port REN, output, 12: read enables onto BIN; same bit order as WEN.
REQ-008 SHALL have port LDALU, output, 6: ALU loads; bit order [0]IR [1]IDX [2]IDY [3]R1 [4]R5 [5]AC.
REQ-009 SHALL have port RSTR, output, 7: register clears, R1..R7.
REQ-010 SHALL have ports R2INC, PCINC, MEMREAD, MEMWRITE, output, 1 each: increment and memory strobes.
REQ-011 SHALL have port ALUMUX, output, 3: ALU operation select.
REQ-012 SHALL have ports halted and err, output, 1 each: HALT reached; illegal opcode seen.
REQ-013 SHALL have port instr_count, output, 16: retired-instruction counter.

Function
REQ-014 SHALL implement states IDLE, FETCH, INCPC, DECODE, EX1, EX2, HALT.
REQ-015 SHALL derive all control outputs from the current state and the latched opcode only (Moore); no input-to-output combinational path.
REQ-016 SHALL assert at most one REN bit per cycle, and never drive REN and MEMREAD in the same cycle.
REQ-017 SHALL transition IDLE->FETCH on start=1; otherwise remain in IDLE with all controls 0.
REQ-018 SHALL assert WEN[IR] in FETCH, PCINC in INCPC, and LDALU[IR] in DECODE; in DECODE it SHALL latch IROUT[15:0].
REQ-019 SHALL execute opcodes as follows; any opcode finishing in DECODE goes to FETCH next:
  - 0x0 NOP: finishes in DECODE.
  - 0x1 LDAC: EX1 MEMREAD+WEN[DR]; EX2 REN[DR]+WEN[AC].
  - 0x2 STAC: EX1 REN[AC]+WEN[DR]; EX2 MEMWRITE.
  - 0x3 MVAR: EX1 REN[reg]+WEN[AR]; field 0 selects AC.
  - 0x4 ALU: EX1 REN[reg]+LDALU[AC]+ALUMUX=IR[11:9]; EX2 WEN[AC].
  - 0x5 INCR2: EX1 R2INC.
  - 0x6 CLR: EX1 RSTR[field-1]; field 0 means no clear.
  - 0x7 JMP: EX1 REN[IR]+WEN[PC].
  - 0x8 JMPZ: as JMP when ZFLAG=1 (sampled in EX1), else no enables.
  - 0xF HALT: DECODE->HALT.
REQ-020 SHALL send single-EX opcodes EX1->FETCH and two-EX opcodes EX2->FETCH.
REQ-021 SHALL treat opcodes 0x9-0xE as illegal: DECODE->HALT, with err set.
REQ-022 SHALL make HALT terminal until rst: halted=1, all controls 0, start ignored.
REQ-023 SHALL increment instr_count by 1 on each transition into FETCH from DECODE, EX1 or EX2, wrapping 0xFFFF->0x0000; HALT and illegal opcodes SHALL NOT count.
REQ-024 SHALL take 3 cycles for NOP/HALT decode, 4 cycles for single-EX opcodes, and 5 cycles for two-EX opcodes.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, force state IDLE, clear the latched opcode, instr_count, halted and err to 0, and drive all control outputs 0 from the next cycle.
REQ-026 SHALL give rst priority over start and over any state, including mid-instruction; the aborted instruction is not counted.

Configuration
REQ-027 SHALL, with CTRL_SINGLE_STEP_EN defined, add input step (1 bit) and return to IDLE after each retired instruction instead of FETCH; a start or step pulse then begins the next fetch.
REQ-028 SHALL, without CTRL_SINGLE_STEP_EN, have no step port and run continuously from FETCH to FETCH.

Verification
REQ-029 SHALL cover reset then start with IROUT=0x0000 -> WEN=0x008, then PCINC, then LDALU=0x01, FETCH again; instr_count=1 after the first loop.
REQ-030 SHALL cover IROUT=0x1000 -> EX1 MEMREAD=1, WEN=0x002; EX2 REN=0x002, WEN=0x800; 5 cycles total.
REQ-031 SHALL cover IROUT=0x8000 with ZFLAG=0 -> no PC write; with ZFLAG=1 -> REN=0x008, WEN=0x004.
REQ-032 SHALL cover IROUT=0x6002 -> RSTR=0x02; IROUT=0x6000 -> RSTR=0x00.
REQ-033 SHALL cover IROUT=0xA000 -> halted=1, err=1, instr_count unchanged; start ignored; rst -> IDLE with all outputs 0.
REQ-034 SHALL cover instr_count preset to 0xFFFF by running 65535 NOPs, then one more NOP -> 0x0000; and rst asserted during EX1 -> IDLE next cycle, count unchanged.
